// File: rtl/wiegand_tx_if.sv
// Wiegand-26 transmitter bus: frame request/capture and the D0/D1 line pair with status.
interface wiegand_tx_if;
  logic        start;
  logic [23:0] card_id;
  logic [1:0]  wil;
  logic        busy;
  logic        done;

  // Requester side: issues frames and observes the line and status.
  modport master (
    output start,
    output card_id,
    input  wil,
    input  busy,
    input  done
  );

  // Transmitter side.
  modport slave (
    input  start,
    input  card_id,
    output wil,
    output busy,
    output done
  );
endinterface

// File: rtl/wiegand_tx.sv
// Wiegand-26 transmitter: frames a 24-bit card number with two parity bits and sends it
// MSB first as active-low pulses on D0 (wil[0]) / D1 (wil[1]). All outputs are registered.
module wiegand_tx #(
  parameter int unsigned PULSE_W = 100,
  parameter int unsigned GAP_W   = 2000,
  parameter int unsigned GUARD_W = 6000
) (
  input  logic         wil_clk,
  input  logic         nReset,
  wiegand_tx_if.slave  bus
);

  localparam logic [15:0] PulseLast = 16'(PULSE_W - 1);
  localparam logic [15:0] GapLast   = 16'(GAP_W - 1);
  localparam logic [15:0] GuardLast = 16'(GUARD_W - 1);
  localparam logic [4:0]  LastBit   = 5'd25;

  typedef enum logic [1:0] {StIdle, StPulse, StGap, StGuard} state_e;

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [25:0] frame_q, frame_d;
  logic [1:0]  wil_q, wil_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cur_bit;

  // Next-state logic; outputs are derived from the next state so they register in step with it.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + 16'd1;
    bitcnt_d = bitcnt_q;
    frame_d  = frame_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (bus.start) begin
          // Even parity over the upper half leads, odd parity over the lower half trails.
          frame_d  = {^bus.card_id[23:12], bus.card_id, ~^bus.card_id[11:0]};
          bitcnt_d = '0;
          state_d  = StPulse;
        end
      end
      StPulse: begin
        if (timer_q == PulseLast) begin
          timer_d = '0;
          if (bitcnt_q == LastBit) begin
            state_d = StGuard;
          end else begin
            bitcnt_d = bitcnt_q + 5'd1;
            state_d  = StGap;
          end
        end
      end
      StGap: begin
        if (timer_q == GapLast) begin
          timer_d = '0;
          state_d = StPulse;
        end
      end
      StGuard: begin
        if (timer_q == GuardLast) begin
          timer_d = '0;
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: begin
        timer_d = '0;
        state_d = StIdle;
      end
    endcase

    cur_bit = frame_d[LastBit - bitcnt_d];
    wil_d   = (state_d == StPulse) ? (cur_bit ? 2'b01 : 2'b10) : 2'b11;
    busy_d  = (state_d != StIdle);
  end

  // State and output registers; reset releases both lines high at once.
  always_ff @(posedge wil_clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      bitcnt_q <= '0;
      frame_q  <= '0;
      wil_q    <= 2'b11;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      frame_q  <= frame_d;
      wil_q    <= wil_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.wil  = wil_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_wiegand_tx.sv
// Self-checking bench for wiegand_tx: randomized frames against a parity-rule model, with a
// line monitor that decodes pulses, times them and scores each completed frame.
module tb_wiegand_tx;
  localparam int unsigned PW = 2;
  localparam int unsigned GW = 3;
  localparam int unsigned UW = 5;
  localparam int FrameCyc = 26 * PW + 25 * GW + UW;

  logic wil_clk;
  logic nReset;
  wiegand_tx_if bus ();

  wiegand_tx #(.PULSE_W(PW), .GAP_W(GW), .GUARD_W(UW)) dut (
    .wil_clk (wil_clk),
    .nReset  (nReset),
    .bus     (bus)
  );

  initial wil_clk = 1'b0;
  always #5 wil_clk = ~wil_clk;

  int checks = 0;
  int errors = 0;
  logic [25:0] exp_q[$];

  // Monitor state, also read by the stimulus process.
  int          nbits;
  int          ndone;
  logic [25:0] cap;
  logic [1:0]  prev_wil;
  int          pulse_len, gap_len, frame_cyc;
  bit          in_frame;

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference frame from the parity rules.
  function automatic logic [25:0] frame_of(input logic [23:0] c);
    int ones_hi, ones_lo;
    ones_hi = 0;
    ones_lo = 0;
    for (int i = 0; i < 12; i++) begin
      ones_hi += int'(c[12 + i]);
      ones_lo += int'(c[i]);
    end
    return {1'(ones_hi % 2), c, 1'((ones_lo % 2) == 0)};
  endfunction

  // Line monitor and scoreboard.
  always @(negedge wil_clk) begin
    if (!nReset) begin
      nbits = 0; cap = '0; prev_wil = 2'b11; pulse_len = 0; gap_len = 0;
      frame_cyc = 0; in_frame = 0;
    end else begin
      if (in_frame) frame_cyc++;
      if (bus.done === 1'b1) begin
        ndone++;
        chk(exp_q.size() > 0, "done_expected", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
          logic [25:0] e;
          e = exp_q.pop_front();
          chk(cap === e, "frame_bits", 32'(cap), 32'(e));
          chk(nbits == 26, "frame_len", 32'(nbits), 32'd26);
          chk(frame_cyc == FrameCyc, "frame_dur", 32'(frame_cyc), 32'(FrameCyc));
          chk(gap_len == UW, "guard_w", 32'(gap_len), 32'(UW));
          chk(bus.busy === 1'b0, "busy_in_done", 32'(bus.busy), 32'd0);
        end
        in_frame = 0;
        nbits = 0;
      end
      if (bus.wil === 2'b11) begin
        if (prev_wil != 2'b11) begin
          chk(pulse_len == PW, "pulse_w", 32'(pulse_len), 32'(PW));
          gap_len = 1;
        end else begin
          gap_len++;
        end
      end else if (bus.wil === 2'b10 || bus.wil === 2'b01) begin
        if (prev_wil != bus.wil) begin
          if (nbits > 0) chk(gap_len == GW, "gap_w", 32'(gap_len), 32'(GW));
          if (!in_frame) begin
            in_frame = 1;
            frame_cyc = 0;
          end
          chk(bus.busy === 1'b1, "busy_in_pulse", 32'(bus.busy), 32'd1);
          cap = {cap[24:0], bus.wil[1] ? 1'b0 : 1'b1};
          cap = {cap[25:1], bus.wil == 2'b01};
          nbits++;
          pulse_len = 1;
        end else begin
          pulse_len++;
        end
      end else begin
        chk(1'b0, "line_state", 32'(bus.wil), 32'h3);
      end
      prev_wil = bus.wil;
    end
  end

  task automatic tick();
    @(posedge wil_clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) chk(1'b0, "idle_timeout", 32'(n), 32'd1000);
  endtask

  task automatic wait_done();
    int n = 0;
    while (bus.done !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) chk(1'b0, "done_timeout", 32'(n), 32'd1000);
  endtask

  // One-cycle start; card_id is scrambled afterwards, which must not affect the frame.
  task automatic send(input logic [23:0] c);
    wait_idle();
    bus.card_id = c;
    bus.start = 1'b1;
    exp_q.push_back(frame_of(c));
    tick();
    bus.start = 1'b0;
    bus.card_id = 24'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d0;
    bus.start = 1'b0;
    bus.card_id = '0;
    nReset = 1'b0;
    ndone = 0;

    // Reset holds the line idle whatever start does.
    for (int i = 0; i < 4; i++) begin
      bus.start = ~bus.start;
      tick();
      chk(bus.wil === 2'b11, "rst_wil", 32'(bus.wil), 32'h3);
      chk(bus.busy === 1'b0 && bus.done === 1'b0, "rst_busy_done",
          32'({bus.busy, bus.done}), 32'd0);
    end
    bus.start = 1'b0;
    #2 nReset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk(bus.wil === 2'b11 && bus.busy === 1'b0, "post_rst_idle",
          32'({bus.wil, bus.busy}), 32'h6);
    end

    // Directed and random frames.
    send(24'hABCDEF); wait_done(); tick();
    send(24'h000000); wait_done(); tick();
    send(24'hFFFFFF); wait_done(); tick();
    send(24'h123456); wait_done(); tick();
    for (int i = 0; i < 6; i++) begin
      send(24'($urandom));
      wait_done();
      tick();
    end

    // Starts while busy are dropped: one frame only.
    d0 = ndone;
    send(24'($urandom));
    for (int i = 0; i < 400 && bus.busy === 1'b1; i++) begin
      bus.start = (i % 3 == 0);
      bus.card_id = 24'($urandom);
      tick();
    end
    bus.start = 1'b0;
    repeat (60) tick();
    chk(ndone - d0 == 1, "ignored_starts_done", 32'(ndone - d0), 32'd1);
    chk(bus.busy === 1'b0, "ignored_starts_idle", 32'(bus.busy), 32'd0);
    chk(exp_q.size() == 0, "ignored_starts_queue", 32'(exp_q.size()), 32'd0);

    // Start held across done gives a back-to-back frame beginning right after done.
    wait_idle();
    bus.card_id = 24'($urandom);
    bus.start = 1'b1;
    exp_q.push_back(frame_of(bus.card_id));
    tick();
    bus.card_id = 24'($urandom);
    exp_q.push_back(frame_of(bus.card_id));
    wait_done();
    tick();
    chk(bus.wil !== 2'b11, "b2b_first_pulse", 32'(bus.wil), 32'h1);
    bus.start = 1'b0;
    bus.card_id = 24'($urandom);
    wait_done();
    tick();

    // Reset in the middle of bit 10's pulse.
    d0 = ndone;
    send(24'($urandom));
    for (int n = 0; n < 1000 && nbits < 11; n++) tick();
    chk(nbits == 11 && bus.wil !== 2'b11, "abort_reached", 32'(nbits), 32'd11);
    #2 nReset = 1'b0;
    #1;
    chk(bus.wil === 2'b11, "abort_wil_async", 32'(bus.wil), 32'h3);
    chk(bus.busy === 1'b0 && bus.done === 1'b0, "abort_flags", 32'({bus.busy, bus.done}), 32'd0);
    exp_q.delete();
    repeat (3) tick();
    #2 nReset = 1'b1;
    repeat (200) tick();
    chk(ndone == d0, "abort_no_done", 32'(ndone - d0), 32'd0);
    chk(bus.wil === 2'b11 && bus.busy === 1'b0, "abort_idle", 32'({bus.wil, bus.busy}), 32'h6);

    // Transmitter still works after an abort.
    send(24'($urandom)); wait_done(); tick();
    chk(exp_q.size() == 0, "final_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
